// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mc_pkg                                                 |
// | Description : Shared encodings for the multi-cycle main controller:  |
// |               FSM states, opcodes and datapath mux/ALUOp encodings.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mc_pkg;

  // Controller states; 11 states fit in a 4-bit register
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  // Supported opcodes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALUOp requests to the ALU control unit (11 is never driven)
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ImmSrc encodings
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_imm_src_dec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mc_imm_src_dec                                         |
// | Description : Combinational opcode -> immediate format decode.       |
// |               Shared with the single-cycle decoder.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mc_imm_src_dec
  import mc_pkg::*;
(
  input  logic [6:0] op_i,
  output logic [1:0] imm_src_o
);

  // Map opcode to immediate format; unknown opcodes fall back to I-type
  always_comb begin
    imm_src_o = IMM_I;
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_main_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mc_main_controller                                     |
// | Description : Multi-cycle main control FSM (Moore). Sequences fetch, |
// |               decode, execute, memory and writeback and drives the   |
// |               datapath enables, mux selects and ALUOp.               |
// |               Optional: define MC_INSTRET_EN to add the 32-bit       |
// |               retired-instruction counter output instret.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mc_main_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic        zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ImmSrc,
`ifdef MC_INSTRET_EN
  output logic [31:0] instret,
`endif
  output logic        illegal
);

  state_e state_q, state_d;

  logic pc_update, branch, mem_write, ir_write, reg_write, illegal_op;

  // State register; reset lands directly in FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state output decode
  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUOp      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_update = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here from OldPC + imm
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTER;
          OP_ITYPE:     state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUOp   = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are masked while reset is high so that no write can
  // complete from the FETCH decode that reset forces.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign MemWrite = ~reset & mem_write;
  assign IRWrite  = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;
  assign illegal  = ~reset & illegal_op;

  mc_imm_src_dec u_imm_src_dec (
    .op_i      (op),
    .imm_src_o (ImmSrc)
  );

`ifdef MC_INSTRET_EN
  logic [31:0] instret_q;

  // Count instructions retiring into FETCH; illegal ops leave via DECODE and are not counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= 32'd0;
    end else if (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                 state_q == S_ALUWB || state_q == S_BEQ) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_main_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mc_main_controller                                  |
// | Description : Scoreboard bench for mc_main_controller. A driver      |
// |               issues instructions and queues the expected per-cycle  |
// |               outputs; a monitor pops and compares on each negedge.  |
// |               Checks instret as well when MC_INSTRET_EN is defined.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mc_main_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
`ifdef MC_INSTRET_EN
  logic [31:0] instret;
`endif

  mc_main_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
`ifdef MC_INSTRET_EN
    .instret   (instret),
`endif
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Instruction classes of the reference model
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

  typedef struct {
    string       phase;
    logic [15:0] outs;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ret_model = 0;

  // Immediate format implied by an opcode
  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  // Expected output bundle for a named step of an instruction
  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,illegal}
  function automatic logic [15:0] expect_outs(input string ph, input logic [6:0] o, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, a = 0, b = 0, aop = 0;
    if (ph == "RESET") begin
      b = 2'b10; res = 2'b10;
    end else if (ph == "FETCH") begin
      irw = 1; pcw = 1; b = 2'b10; res = 2'b10;
    end else if (ph == "DECODE" || ph == "DECODE_ILL") begin
      a = 2'b01; b = 2'b01; ill = (ph == "DECODE_ILL");
    end else if (ph == "MEMADR") begin
      a = 2'b10; b = 2'b01;
    end else if (ph == "MEMREAD") begin
      adr = 1;
    end else if (ph == "MEMWB") begin
      res = 2'b01; rw = 1;
    end else if (ph == "MEMWRITE") begin
      adr = 1; mw = 1;
    end else if (ph == "EXECUTER") begin
      a = 2'b10; aop = 2'b10;
    end else if (ph == "EXECUTEI") begin
      a = 2'b10; b = 2'b01; aop = 2'b10;
    end else if (ph == "JAL") begin
      a = 2'b01; b = 2'b10; pcw = 1;
    end else if (ph == "ALUWB") begin
      rw = 1;
    end else if (ph == "BEQ") begin
      a = 2'b10; aop = 2'b01; pcw = z;
    end
    return {pcw, adr, mw, irw, rw, res, a, b, aop, imm_of(o), ill};
  endfunction

  function automatic int len_of(input int kind);
    case (kind)
      K_LW:    return 5;
      K_BEQ:   return 3;
      K_ILL:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic string phase_of(input int kind, input int step);
    if (step == 0) return "FETCH";
    if (step == 1) return (kind == K_ILL) ? "DECODE_ILL" : "DECODE";
    case (kind)
      K_LW:    return (step == 2) ? "MEMADR" : (step == 3) ? "MEMREAD" : "MEMWB";
      K_SW:    return (step == 2) ? "MEMADR" : "MEMWRITE";
      K_R:     return (step == 2) ? "EXECUTER" : "ALUWB";
      K_I:     return (step == 2) ? "EXECUTEI" : "ALUWB";
      K_JAL:   return (step == 2) ? "JAL" : "ALUWB";
      default: return "BEQ";
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
  endfunction

  function automatic logic [6:0] op_for(input int kind);
    logic [6:0] r;
    case (kind)
      K_LW:  return 7'b0000011;
      K_SW:  return 7'b0100011;
      K_R:   return 7'b0110011;
      K_I:   return 7'b0010011;
      K_JAL: return 7'b1101111;
      K_BEQ: return 7'b1100011;
      default: begin
        r = 7'($urandom);
        while (is_legal(r)) r = 7'($urandom);
        return r;
      end
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string ph);
    exp_t e;
    e.phase = ph;
    e.outs  = expect_outs(ph, op, zero);
    e.ret   = 32'(ret_model);
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Run one instruction; zmode 0/1 forces zero, 2 randomises it each cycle.
  // scramble drives random op in cycles where the controller must ignore it.
  // stop_at < 0 runs to completion, otherwise stops after that step.
  task automatic run_instr(input int kind, input int zmode, input bit scramble, input int stop_at);
    logic [6:0] iop;
    bit         op_live;
    iop = (kind == K_ILL && !scramble) ? 7'b1111111 : op_for(kind);
    for (int step = 0; step < len_of(kind); step++) begin
      next_cycle();
      reset = 1'b0;
      op_live = (step == 1) || (step == 2 && (kind == K_LW || kind == K_SW));
      op   = (scramble && !op_live) ? 7'($urandom) : iop;
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      push(phase_of(kind, step));
      if (step == stop_at) return;
    end
    if (kind != K_ILL) ret_model++;
  endtask

  // Monitor: compare every queued expectation away from the active edge
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};
        check({"outs_", e.phase}, {16'h0, act}, {16'h0, e.outs});
`ifdef MC_INSTRET_EN
        check({"instret_", e.phase}, instret, e.ret);
`endif
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    reset = 1'b1;
    op    = 7'b0110011;
    zero  = 1'b0;
    repeat (3) begin
      next_cycle();
      push("RESET");
    end

    // Directed sequence
    run_instr(K_LW,  0, 1'b0, -1);
    run_instr(K_R,   0, 1'b0, -1);
    run_instr(K_BEQ, 1, 1'b0, -1);
    run_instr(K_BEQ, 0, 1'b0, -1);
    run_instr(K_ILL, 0, 1'b0, -1);
    run_instr(K_SW,  0, 1'b0, -1);
    run_instr(K_I,   0, 1'b0, -1);
    run_instr(K_JAL, 0, 1'b0, -1);

    // Reset asserted in the middle of a MEMWRITE cycle
    run_instr(K_SW, 0, 1'b0, 3);
    #5;
    reset = 1'b1;
    #1;
    check("rst_memwrite",  {31'h0, MemWrite}, 32'h0);
    check("rst_irwrite",   {31'h0, IRWrite},  32'h0);
    check("rst_pcwrite",   {31'h0, PCWrite},  32'h0);
    check("rst_alusrcb",   {30'h0, ALUSrcB},  32'h2);
    check("rst_resultsrc", {30'h0, ResultSrc}, 32'h2);
`ifdef MC_INSTRET_EN
    check("rst_instret", instret, 32'h0);
`endif
    ret_model = 0;
    next_cycle();
    push("RESET");

    // Randomised instruction stream
    for (int n = 0; n < 200; n++) begin
      run_instr(int'($urandom_range(0, 6)), 2, 1'b1, -1);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
